// File: rtl/spi_master_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_gen
// Purpose  : Parametrised SPI master running entirely on i_sys_clk. Supports
//            all four CPOL/CPHA modes, MSB/LSB-first ordering, a runtime SCK
//            divider and NUM_SS active-low slave selects.
// Optional : define SPI_BURST_EN to add i_burst (back-to-back words with SS
//            held low between them).
// Ports    : i_sys_clk/i_sys_rst  clock, async active-low reset
//            i_start, i_data, i_ss_sel, i_cpol, i_cpha, i_lsb_first, i_div
//                                 request + per-word config (latched on start)
//            i_MISO / o_SCK / o_MOSI / o_SS_n   SPI pins
//            o_busy, o_done, o_data             host status / received word
// Revision : 1.0  initial release
// ============================================================================
module spi_master_gen #(
  parameter  int DATA_W = 8,
  parameter  int NUM_SS = 4,
  parameter  int DIV_W  = 8,
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_ss_sel,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [DIV_W-1:0]  i_div,
`ifdef SPI_BURST_EN
  input  logic              i_burst,
`endif
  input  logic              i_MISO,
  output logic              o_SCK,
  output logic              o_MOSI,
  output logic [NUM_SS-1:0] o_SS_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data
);

  localparam int            EW          = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] c_LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state, w_next;
  logic [DIV_W-1:0]    r_cnt, r_div;
  logic [EW-1:0]       r_edge, w_edge_idx;
  logic [DATA_W-1:0]   r_tx, r_rx, r_data;
  logic [NUM_SS-1:0]   r_ss_n, w_ss_dec;
  logic                r_cpha, r_lsb, r_sck, r_mosi, r_done;
  logic                w_sel_ok, w_wrap, w_accept, w_edge_ev, w_burst_go;
  logic                w_finish, w_burst_req, w_lead;

  // Bit that goes on the wire next, and the word after it has been sent.
  function automatic logic f_head(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] f_advance(input logic [DATA_W-1:0] d,
                                                  input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  // When NUM_SS fills the select field every index is valid.
  generate
    if ((1 << SEL_W) == NUM_SS) begin : g_sel_full
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_cmp
      assign w_sel_ok = ({1'b0, i_ss_sel} < (SEL_W + 1)'(NUM_SS));
    end
  endgenerate

`ifdef SPI_BURST_EN
  assign w_burst_req = i_burst;
`else
  assign w_burst_req = 1'b0;
`endif

  assign w_ss_dec = ~(NUM_SS'(1) << i_ss_sel);
  assign w_wrap   = (r_cnt == r_div);
  assign w_lead   = ~w_edge_idx[0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // Next state and per-cycle events
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_edge_ev  = 1'b0;
    w_edge_idx = r_edge;
    w_burst_go = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_sel_ok) begin
          w_accept = 1'b1;
          w_next   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_wrap) begin
          w_next     = S_XFER;
          w_edge_ev  = 1'b1;
          w_edge_idx = '0;
        end
      end
      S_XFER: begin
        if (w_wrap) begin
          if (r_edge == c_LAST_EDGE) begin
            // SCK is already back at idle after the final trailing edge.
            // A burst reuses SETUP as the idle-level gap before edge 0.
            if (w_burst_req) begin
              w_burst_go = 1'b1;
              w_next     = S_SETUP;
            end else begin
              w_next     = S_HOLD;
            end
          end else begin
            w_edge_ev  = 1'b1;
            w_edge_idx = r_edge + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_wrap) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_edge <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_data <= '0;
      r_ss_n <= '1;
      r_cpha <= 1'b0;
      r_lsb  <= 1'b0;
      r_sck  <= 1'b0;
      r_mosi <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= ((r_state == S_IDLE) || w_wrap) ? '0 : r_cnt + 1'b1;

      if (w_accept) begin
        r_div  <= i_div;
        r_cpha <= i_cpha;
        r_lsb  <= i_lsb_first;
        r_ss_n <= w_ss_dec;
        r_sck  <= i_cpol;
        // CPHA=0 needs the first bit valid before the first leading edge.
        if (!i_cpha) begin
          r_mosi <= f_head(i_data, i_lsb_first);
          r_tx   <= f_advance(i_data, i_lsb_first);
        end else begin
          r_tx   <= i_data;
        end
      end

      if (w_burst_go) begin
        r_done <= 1'b1;
        r_data <= r_rx;
        if (!r_cpha) begin
          r_mosi <= f_head(i_data, r_lsb);
          r_tx   <= f_advance(i_data, r_lsb);
        end else begin
          r_tx   <= i_data;
        end
      end

      if (w_edge_ev) begin
        r_sck  <= ~r_sck;
        r_edge <= w_edge_idx;
        // Launch: leading edges for CPHA=1, trailing (not the last) for CPHA=0.
        if (r_cpha ? w_lead : (!w_lead && (w_edge_idx != c_LAST_EDGE))) begin
          r_mosi <= f_head(r_tx, r_lsb);
          r_tx   <= f_advance(r_tx, r_lsb);
        end
        // Capture on the opposite edge type from launch.
        if (w_lead ^ r_cpha) begin
          r_rx <= r_lsb ? {i_MISO, r_rx[DATA_W-1:1]}
                        : {r_rx[DATA_W-2:0], i_MISO};
        end
      end

      if (w_finish) begin
        r_ss_n <= '1;
        r_done <= 1'b1;
        r_data <= r_rx;
      end
    end
  end

  assign o_SCK  = r_sck;
  assign o_MOSI = r_mosi;
  assign o_SS_n = r_ss_n;
  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_data = r_data;

endmodule
`default_nettype wire
